// File: rtl/sample_iterator.sv
// Walks every sample position of a triangle's bounding box, one sample per cycle.
// Optional ITER_PERF_COUNT_EN adds saturating accept/sample counters on two extra ports.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [SIGFIG-1:0]  tri_R13S   [VERTS][AXIS],
    input  logic        [SIGFIG-1:0]  color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0]  box_R13S   [2][2],
    input  logic                      validTri_R13H,
    input  logic        [3:0]         subSample_RnnnnU,
    output logic                      halt_RnnnnL,
    output logic signed [SIGFIG-1:0]  tri_R14S   [VERTS][AXIS],
    output logic        [SIGFIG-1:0]  color_R14U [COLORS],
    output logic signed [SIGFIG-1:0]  sample_R14S [2],
    output logic                      validSamp_R14H
`ifdef ITER_PERF_COUNT_EN
    ,
    output logic        [31:0]        triCount_RnnnnU,
    output logic        [31:0]        sampCount_RnnnnU
`endif
);

    typedef enum logic {StWait, StTest} state_e;

    localparam logic [SIGFIG-1:0] One = {{(SIGFIG-1){1'b0}}, 1'b1};

    state_e                    r_state, w_state_next;
    logic signed [SIGFIG-1:0]  r_tri    [VERTS][AXIS];
    logic        [SIGFIG-1:0]  r_color  [COLORS];
    logic signed [SIGFIG-1:0]  r_sample [2];
    logic signed [SIGFIG-1:0]  r_ll     [2];
    logic signed [SIGFIG-1:0]  r_ur     [2];
    logic        [SIGFIG-1:0]  r_step;
    logic        [SIGFIG-1:0]  w_step_in;

    // One extra bit so x+step / y+step near the positive limit cannot wrap.
    logic signed [SIGFIG:0]    w_nx, w_ny, w_urx, w_ury;
    logic                      w_x_wrap, w_last, w_empty, w_accept, w_load;

    assign w_nx  = $signed({r_sample[0][SIGFIG-1], r_sample[0]}) + $signed({1'b0, r_step});
    assign w_ny  = $signed({r_sample[1][SIGFIG-1], r_sample[1]}) + $signed({1'b0, r_step});
    assign w_urx = $signed({r_ur[0][SIGFIG-1], r_ur[0]});
    assign w_ury = $signed({r_ur[1][SIGFIG-1], r_ur[1]});

    assign w_x_wrap = (w_nx > w_urx);
    assign w_last   = w_x_wrap && (w_ny > w_ury);
    assign w_empty  = (box_R13S[0][0] > box_R13S[1][0]) || (box_R13S[0][1] > box_R13S[1][1]);

    always_comb begin
        case (subSample_RnnnnU)
            4'b1000: w_step_in = One << RADIX;
            4'b0100: w_step_in = One << (RADIX - 1);
            4'b0010: w_step_in = One << (RADIX - 2);
            4'b0001: w_step_in = One << (RADIX - 3);
            default: w_step_in = One << RADIX;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        halt_RnnnnL  = 1'b1;
        unique case (r_state)
            StWait: halt_RnnnnL = 1'b1;
            StTest: halt_RnnnnL = w_last;
            default: halt_RnnnnL = 1'b1;
        endcase
        w_accept = validTri_R13H && halt_RnnnnL;
        w_load   = w_accept && !w_empty;
        unique case (r_state)
            StWait: if (w_load) w_state_next = StTest;
            StTest: if (w_last) w_state_next = w_load ? StTest : StWait;
            default: w_state_next = StWait;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StWait;
            r_step  <= '0;
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    r_tri[v][a] <= '0;
            for (int c = 0; c < COLORS; c++)
                r_color[c] <= '0;
            for (int k = 0; k < 2; k++) begin
                r_sample[k] <= '0;
                r_ll[k]     <= '0;
                r_ur[k]     <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_tri    <= tri_R13S;
                r_color  <= color_R13U;
                r_step   <= w_step_in;
                r_ll[0]  <= box_R13S[0][0];
                r_ll[1]  <= box_R13S[0][1];
                r_ur[0]  <= box_R13S[1][0];
                r_ur[1]  <= box_R13S[1][1];
                r_sample[0] <= box_R13S[0][0];
                r_sample[1] <= box_R13S[0][1];
            end else if (r_state == StTest && !w_last) begin
                if (!w_x_wrap) begin
                    r_sample[0] <= w_nx[SIGFIG-1:0];
                end else begin
                    r_sample[0] <= r_ll[0];
                    r_sample[1] <= w_ny[SIGFIG-1:0];
                end
            end
        end
    end

    assign validSamp_R14H = (r_state == StTest);
    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = r_sample;

`ifdef ITER_PERF_COUNT_EN
    logic [31:0] r_tri_count, r_samp_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tri_count  <= '0;
            r_samp_count <= '0;
        end else begin
            if (w_accept && r_tri_count != '1)
                r_tri_count <= r_tri_count + 32'd1;
            if (validSamp_R14H && r_samp_count != '1)
                r_samp_count <= r_samp_count + 32'd1;
        end
    end

    assign triCount_RnnnnU  = r_tri_count;
    assign sampCount_RnnnnU = r_samp_count;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Scoreboard bench for sample_iterator: expected samples queued at accept, checked as emitted.
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic clk = 1'b0;
    logic rst;
    logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U  [COLORS];
    logic signed [SIGFIG-1:0] box_R13S    [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnL;
    logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U  [COLORS];
    logic signed [SIGFIG-1:0] sample_R14S [2];
    logic                     validSamp_R14H;
`ifdef ITER_PERF_COUNT_EN
    logic [31:0] triCount_RnnnnU, sampCount_RnnnnU;
`endif

    always #5 clk = ~clk;

    sample_iterator #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
`ifdef ITER_PERF_COUNT_EN
        ,
        .triCount_RnnnnU  (triCount_RnnnnU),
        .sampCount_RnnnnU (sampCount_RnnnnU)
`endif
    );

    typedef struct {
        longint x;
        longint y;
        longint last;
        longint tag;
    } exp_t;

    exp_t   sb[$];
    exp_t   e_cur;
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint first_cyc, last_cyc;
    int     n_valid;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every valid sample must match the head of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst && validSamp_R14H) begin
            if (sb.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                e_cur = sb.pop_front();
                check("sample_x", sample_R14S[0], e_cur.x);
                check("sample_y", sample_R14S[1], e_cur.y);
                check("halt_on_last", halt_RnnnnL, e_cur.last);
                check("tri_tag", tri_R14S[2][1], e_cur.tag * 16 + 7);
                check("color_tag", color_R14U[1], e_cur.tag + 100);
            end
            n_valid++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
    end

    task automatic send(input longint llx, input longint lly, input longint urx,
                        input longint ury, input logic [3:0] ss, input longint tag);
        longint step;
        int     cnt;
        @(negedge clk);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = SIGFIG'(tag * 16 + v * 3 + a);
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = SIGFIG'(tag + c * 100);
        box_R13S[0][0]   = SIGFIG'(llx);
        box_R13S[0][1]   = SIGFIG'(lly);
        box_R13S[1][0]   = SIGFIG'(urx);
        box_R13S[1][1]   = SIGFIG'(ury);
        subSample_RnnnnU = ss;
        validTri_R13H    = 1'b1;
        cnt = 0;
        while (!halt_RnnnnL && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 500) begin
            check("accept_timeout", 0, 1);
            return;
        end
        case (ss)
            4'b1000: step = 1024;
            4'b0100: step = 512;
            4'b0010: step = 256;
            4'b0001: step = 128;
            default: step = 1024;
        endcase
        for (longint y = lly; y <= ury; y += step)
            for (longint x = llx; x <= urx; x += step)
                sb.push_back('{x: x, y: y, last: 0, tag: tag});
        if (llx <= urx && lly <= ury) sb[sb.size()-1].last = 1;
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        validTri_R13H = 1'b0;
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while (sb.size() > 0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_left", sb.size(), 0);
        @(negedge clk);
        check("idle_valid", validSamp_R14H, 0);
    endtask

    initial begin
        rst = 1'b0;
        validTri_R13H = 1'b0;
        subSample_RnnnnU = 4'b1000;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = '0;
        for (int c = 0; c < COLORS; c++) color_R13U[c] = '0;
        for (int k = 0; k < 2; k++) begin
            box_R13S[k][0] = '0;
            box_R13S[k][1] = '0;
        end
        first_cyc = -1;
        last_cyc  = -1;
        n_valid   = 0;
        #3;
        check("rst_valid", validSamp_R14H, 0);
        check("rst_halt", halt_RnnnnL, 1);
        check("rst_sample_x", sample_R14S[0], 0);
        check("rst_tri", tri_R14S[0][0], 0);
        check("rst_color", color_R14U[2], 0);
        @(negedge clk);
        rst = 1'b1;

        // 1x 3x2 grid immediately followed by a 4x box; subSample changes mid-iteration.
        n_valid = 0;
        first_cyc = -1;
        send(0, 0, 2048, 1024, 4'b1000, 1);
        send(0, 0, 1023, 0, 4'b0100, 2);
        drop_valid();
        wait_drain();
        check("b2b_count", n_valid, 8);
        check("b2b_gapless", last_cyc - first_cyc + 1, 8);
`ifdef ITER_PERF_COUNT_EN
        check("tri_count", triCount_RnnnnU, 2);
        check("samp_count", sampCount_RnnnnU, 8);
`endif

        // Empty box is consumed without samples.
        send(2048, 0, 1024, 0, 4'b1000, 3);
        drop_valid();
        for (int i = 0; i < 3; i++) begin
            check("empty_halt", halt_RnnnnL, 1);
            check("empty_valid", validSamp_R14H, 0);
            @(negedge clk);
        end

        send(-512, -256, 0, 0, 4'b0010, 4);
        drop_valid();
        wait_drain();
        send(0, 0, 1024, 0, 4'b0011, 5);
        drop_valid();
        wait_drain();
        send(8387584, 0, 8388607, 0, 4'b1000, 6);
        drop_valid();
        wait_drain();
        send(0, 0, 256, 128, 4'b0001, 7);
        drop_valid();
        wait_drain();

        // Reset pulse while the third sample of a 3x3 box is showing.
        send(0, 0, 2048, 2048, 4'b1000, 8);
        drop_valid();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", validSamp_R14H, 0);
        check("midrst_halt", halt_RnnnnL, 1);
        check("midrst_x", sample_R14S[0], 0);
        check("midrst_y", sample_R14S[1], 0);
        check("midrst_tri", tri_R14S[2][1], 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        send(3072, 1024, 4096, 1024, 4'b1000, 9);
        drop_valid();
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
